ccff_chain_loader: RTL and testbench

- Upstream feeder for a switch-block configuration chain.
- Accepts bitstream words over a valid/ready stream and serialises them MSB-first onto ccff_head.
- Drives a per-bit shift enable that gates the chain's prog_clk.
- Captures the bits falling out of ccff_tail, repacks them into words and returns them as a readback stream, so prior configuration can be verified while a new one is loaded.

---
 rtl/ccff_chain_loader_if.sv | 28 ++
 rtl/ccff_chain_loader.sv | 144 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
// Stream, serial-chain and status signals between a configuration host and the chain loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_last;
  logic              rb_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, s_data, s_valid, ccff_tail, rb_ready,
    input  s_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, rb_last, busy, done
  );

  modport slave (
    input  start, s_data, s_valid, ccff_tail, rb_ready,
    output s_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, rb_last, busy, done
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words MSB-first into a configuration chain and repacks the bits
// falling out of the chain tail into a readback word stream.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  ccff_chain_loader_if.slave bus
);
  localparam int ACC_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FLUSH, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ACC_W-1:0]  word_left_q, word_left_d;
  logic [ACC_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;
  logic              rb_last_q, rb_last_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;

  logic              accept, shift, rb_free, rb_take, last_bit;
  logic [WORD_W-1:0] acc_next;
  logic [ACC_W-1:0]  acc_cnt_inc;

  // shift_en_q is only ever set for a SHIFT cycle with room in the accumulator
  assign shift       = shift_en_q;
  assign accept      = (state_q == LOAD) && bus.s_valid;
  assign rb_take     = rb_valid_q && bus.rb_ready;
  assign rb_free     = !rb_valid_q || bus.rb_ready;
  assign last_bit    = shift && (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign acc_next    = {acc_q[WORD_W-2:0], bus.ccff_tail};
  assign acc_cnt_inc = acc_cnt_q + ACC_W'(1);

  always_ff @(posedge prog_clk) begin
    if (pReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = LOAD;
      LOAD:  if (bus.s_valid) state_d = SHIFT;
      SHIFT: begin
        if (shift) begin
          if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) state_d = FLUSH;
          else if (word_left_q == ACC_W'(1))      state_d = LOAD;
        end
      end
      FLUSH: if (rb_take && rb_last_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready = (state_q == LOAD);
    bus.busy    = (state_q != IDLE);
    bus.done    = (state_q == DONE);
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    word_left_d = word_left_q;
    acc_cnt_d   = acc_cnt_q;
    sreg_d      = sreg_q;
    acc_d       = acc_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = rb_valid_q;
    rb_last_d   = rb_last_q;
    if (rb_take) begin
      rb_valid_d = 1'b0;
      rb_last_d  = 1'b0;
    end
    if ((state_q == IDLE) && bus.start) begin
      bit_cnt_d = '0;
      acc_cnt_d = '0;
    end
    if (accept) begin
      sreg_d      = bus.s_data;
      word_left_d = ACC_W'(WORD_W);
    end
    if (shift) begin
      sreg_d      = {sreg_q[WORD_W-2:0], 1'b0};
      word_left_d = word_left_q - ACC_W'(1);
      bit_cnt_d   = bit_cnt_q + CNT_W'(1);
      // a word completed on this edge bypasses acc when the output slot frees up
      if ((acc_cnt_inc == ACC_W'(WORD_W)) && rb_free) begin
        rb_data_d  = acc_next;
        rb_valid_d = 1'b1;
        rb_last_d  = last_bit;
        acc_cnt_d  = '0;
      end else begin
        acc_d     = acc_next;
        acc_cnt_d = acc_cnt_inc;
      end
    end else if ((acc_cnt_q != '0) && rb_free &&
                 ((acc_cnt_q == ACC_W'(WORD_W)) || (state_q == FLUSH))) begin
      rb_data_d  = acc_q << (ACC_W'(WORD_W) - acc_cnt_q);
      rb_valid_d = 1'b1;
      rb_last_d  = (state_q == FLUSH);
      acc_cnt_d  = '0;
    end
    shift_en_d = (state_d == SHIFT) && (acc_cnt_d != ACC_W'(WORD_W));
    head_d     = (state_d == SHIFT) ? sreg_d[WORD_W-1] : 1'b0;
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      bit_cnt_q   <= '0;
      word_left_q <= '0;
      acc_cnt_q   <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      rb_last_q   <= 1'b0;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      word_left_q <= word_left_d;
      acc_cnt_q   <= acc_cnt_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
      rb_last_q   <= rb_last_d;
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
    end
    sreg_q <= sreg_d;
    acc_q  <= acc_d;
  end

  assign bus.ccff_head     = head_q;
  assign bus.ccff_shift_en = shift_en_q;
  assign bus.rb_data       = rb_data_q;
  assign bus.rb_valid      = rb_valid_q;
  assign bus.rb_last       = rb_last_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 24-bit and a 20-bit loader, each feeding a model chain.
module tb_ccff_chain_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, s_valid, rb_ready, sel;
  logic [7:0] s_data;
  logic       s_ready, head, shift_en, rb_valid, rb_last, busy, done;
  logic [7:0] rb_data;

  logic [23:0] chain_a = '0;
  logic [19:0] chain_b = '0;
  int checks = 0;
  int failures = 0;
  int sh_cnt = 0, rdy_cnt = 0, done_cnt = 0, rb_n = 0;
  logic [8:0] rb_log [0:127];

  ccff_chain_loader_if #(.WORD_W(8)) ifa ();
  ccff_chain_loader_if #(.WORD_W(8)) ifb ();

  ccff_chain_loader #(.CHAIN_LEN(24), .WORD_W(8)) dut_a (.prog_clk(clk), .pReset(rst), .bus(ifa));
  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_b (.prog_clk(clk), .pReset(rst), .bus(ifb));

  assign ifa.start     = start & ~sel;
  assign ifa.s_valid   = s_valid & ~sel;
  assign ifa.s_data    = s_data;
  assign ifa.rb_ready  = rb_ready;
  assign ifa.ccff_tail = chain_a[23];
  assign ifb.start     = start & sel;
  assign ifb.s_valid   = s_valid & sel;
  assign ifb.s_data    = s_data;
  assign ifb.rb_ready  = rb_ready;
  assign ifb.ccff_tail = chain_b[19];

  assign s_ready  = sel ? ifb.s_ready       : ifa.s_ready;
  assign head     = sel ? ifb.ccff_head     : ifa.ccff_head;
  assign shift_en = sel ? ifb.ccff_shift_en : ifa.ccff_shift_en;
  assign rb_data  = sel ? ifb.rb_data       : ifa.rb_data;
  assign rb_valid = sel ? ifb.rb_valid      : ifa.rb_valid;
  assign rb_last  = sel ? ifb.rb_last       : ifa.rb_last;
  assign busy     = sel ? ifb.busy          : ifa.busy;
  assign done     = sel ? ifb.done          : ifa.done;

  // downstream chains: shift in head at the LSB, oldest bit leaves at the MSB
  always @(posedge clk) begin
    if (ifa.ccff_shift_en) chain_a <= {chain_a[22:0], ifa.ccff_head};
    if (ifb.ccff_shift_en) chain_b <= {chain_b[18:0], ifb.ccff_head};
  end

  always @(negedge clk) begin
    if (shift_en) sh_cnt <= sh_cnt + 1;
    if (s_ready)  rdy_cnt <= rdy_cnt + 1;
    if (done)     done_cnt <= done_cnt + 1;
    if (rb_valid && rb_ready && rb_n < 128) begin
      rb_log[rb_n] <= {rb_last, rb_data};
      rb_n <= rb_n + 1;
    end
  end

  typedef struct packed {
    logic        sel;
    logic [23:0] words;
    int          gap;
    int          stall;
    logic        start_mid;
    logic [23:0] rb;
    logic [23:0] chain;
    int          ready_cyc;
    int          sh_rel;
    int          exp_sh;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_load(input vec_t v, input string tag);
    int sh0, rdy0, dn0, rb0, sh_rel, tmo1, tmo2, n;
    logic [23:0] chain_now;
    sh0 = sh_cnt; rdy0 = rdy_cnt; dn0 = done_cnt; rb0 = rb_n;
    sh_rel = 0; tmo1 = 0; tmo2 = 0;
    sel = v.sel;
    rb_ready = (v.stall == 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int nf;
          if (v.gap > 0 && i > 0) begin
            nf = 0;
            do begin @(negedge clk); nf++; end while (!s_ready && nf < 300);
            if (nf >= 300) tmo1++;
            repeat (v.gap - 1) @(negedge clk);
            @(posedge clk); #1;
          end
          s_data = v.words[8*(2-i) +: 8];
          s_valid = 1'b1;
          nf = 0;
          do begin @(negedge clk); nf++; end while (!s_ready && nf < 300);
          if (nf >= 300) tmo1++;
          @(posedge clk); #1 s_valid = 1'b0;
          if (v.start_mid && i == 0) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
          end
        end
      end
      begin
        if (v.stall > 0) begin
          int ns;
          ns = 0;
          do begin @(negedge clk); ns++; end while (!rb_valid && ns < 300);
          if (ns >= 300) tmo2++;
          repeat (v.stall) @(negedge clk);
          @(posedge clk); #1 rb_ready = 1'b1;
          sh_rel = sh_cnt - sh0;
        end
      end
    join
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 500);
    chk({tag, "_timeout"}, tmo1 + tmo2, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_shifts"}, sh_cnt - sh0, v.exp_sh);
    chk({tag, "_done"}, done_cnt - dn0, 1);
    chk({tag, "_ready_cyc"}, rdy_cnt - rdy0, v.ready_cyc);
    chk({tag, "_rb_words"}, rb_n - rb0, 3);
    for (int j = 0; j < 3; j++) begin
      if (rb0 + j < 128) begin
        chk($sformatf("%s_rb%0d", tag, j), rb_log[rb0+j][7:0], v.rb[8*(2-j) +: 8]);
        chk($sformatf("%s_last%0d", tag, j), rb_log[rb0+j][8], (j == 2));
      end
    end
    if (v.sh_rel > 0) chk({tag, "_shifts_at_release"}, sh_rel, v.sh_rel);
    chain_now = v.sel ? {4'h0, chain_b} : chain_a;
    chk({tag, "_chain"}, chain_now, v.chain);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, sh0;
    vec_t clean;
    //            sel  words        gap stall mid  rb           chain        rdy rel  sh
    vecs[0] = '{1'b0, 24'hA53CF0, 0, 0,  1'b0, 24'h000000, 24'hA53CF0, 3,  0,  24};
    vecs[1] = '{1'b0, 24'h123456, 0, 0,  1'b0, 24'hA53CF0, 24'h123456, 3,  0,  24};
    vecs[2] = '{1'b0, 24'hA53CF0, 5, 0,  1'b0, 24'h123456, 24'hA53CF0, 13, 0,  24};
    vecs[3] = '{1'b0, 24'h0F77C3, 0, 12, 1'b0, 24'hA53CF0, 24'h0F77C3, 3,  16, 24};
    vecs[4] = '{1'b1, 24'hA53CF0, 0, 0,  1'b0, 24'h000000, 24'h0A53CF, 3,  0,  20};
    vecs[5] = '{1'b1, 24'h123456, 0, 0,  1'b0, 24'hA53CF0, 24'h012345, 3,  0,  20};

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; rb_ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", {ifa.s_ready, ifa.ccff_head, ifa.ccff_shift_en, ifa.rb_data,
                    ifa.rb_valid, ifa.rb_last, ifa.busy, ifa.done}, 0);
    chk("reset_b", {ifb.s_ready, ifb.ccff_head, ifb.ccff_shift_en, ifb.rb_data,
                    ifb.rb_valid, ifb.rb_last, ifb.busy, ifb.done}, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) run_load(vecs[i], $sformatf("load%0d", i));

    // abort a load of all-ones after 10 bits have entered chain A
    sel = 1'b0; rb_ready = 1'b1; sh0 = sh_cnt;
    @(posedge clk); #1 start = 1'b1; s_data = 8'hFF; s_valid = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0; n = 0;
    while (k < 10 && n < 200) begin
      @(negedge clk); n++;
      if (shift_en) k++;
    end
    chk("abort_reach", k, 10);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {ifa.s_ready, ifa.ccff_head, ifa.ccff_shift_en, ifa.rb_data,
                          ifa.rb_valid, ifa.rb_last, ifa.busy, ifa.done}, 0);
    s_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_shifts", sh_cnt - sh0, 10);
    chk("abort_chain", chain_a, 24'hDF0FFF);
    chk("abort_idle", busy, 0);

    clean = '{1'b0, 24'h5AC381, 0, 0, 1'b1, 24'hDF0FFF, 24'h5AC381, 3, 0, 24};
    run_load(clean, "clean");
    repeat (4) @(negedge clk);
    chk("post_idle", {busy, s_ready, shift_en}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
